kbd_event_ctrl: RTL

//  Sequences the PS/2 receive FIFO (ps2_keyboard) via its ready/nextdata_n pop handshake.

---
 rtl/kbd_pkg.sv | 26 ++
 rtl/kbd_evt_fifo.sv | 53 +++++
 rtl/kbd_event_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/kbd_pkg.sv
// Shared scancode constants, FSM state encoding and event field layout
// for the PS/2 keyboard event controller.
package kbd_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ALT    = 8'h11;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_ERR0   = 8'h00;
    localparam logic [7:0] SC_ERR1   = 8'hFF;

    localparam int EVT_W   = 10;
    localparam int EVT_BRK = 9;
    localparam int EVT_EXT = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_POP,
        ST_PARSE
    } kbd_state_t;

endpackage

// File: rtl/kbd_evt_fifo.sv
// Synchronous event FIFO with registered pointers; a write while full is
// accepted only when a read retires the head in the same cycle.
module kbd_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_rd_ok;
    logic             w_wr_ok;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == FULL_CNT);
    assign o_rdata = r_mem[r_rptr];
    assign w_rd_ok = i_rd & ~o_empty;
    assign w_wr_ok = i_wr & (~o_full | w_rd_ok);

    always_ff @(posedge clk) begin
        if (w_wr_ok) r_mem[r_wptr] <= i_wdata;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_ok) r_wptr <= r_wptr + AW'(1);
            if (w_rd_ok) r_rptr <= r_rptr + AW'(1);
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/kbd_event_ctrl.sv
// Pops PS/2 scancode bytes, parses make/break/E0/E1 sequences into 10-bit
// key events, tracks modifiers/caps and queues events for the consumer.
module kbd_event_ctrl
    import kbd_pkg::*;
#(
    parameter int EVQ_DEPTH  = 4,
    parameter bit REPEAT_EN  = 1'b0,
    parameter int PAUSE_SKIP = 7
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [7:0]       ps2_data,
    input  logic             ps2_ready,
    output logic             ps2_nextdata_n,
    output logic [EVT_W-1:0] evt_data,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic             shift,
    output logic             ctrl,
    output logic             alt,
    output logic             caps,
    output logic [7:0]       make_count,
    output logic             evt_overflow,
    output logic [7:0]       err_count
);

    kbd_state_t r_state, w_next;
    logic [7:0] r_byte;
    logic       r_nextdata_n;
    logic       r_ext, r_brk;
    logic [7:0] r_skip;
    logic [8:0] r_last_make;
    logic       r_last_valid;
    logic       r_shl, r_shr, r_ctl, r_ctr, r_altl, r_altr, r_caps;
    logic [7:0] r_make_cnt, r_err_cnt;
    logic       r_ovf;

    logic       w_parse, w_prefix, w_is_key, w_repeat, w_evt_wr;
    logic       w_full, w_empty, w_pop, w_accept;
    logic [8:0] w_key;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (ps2_ready) w_next = ST_POP;
            ST_POP:   w_next = ST_PARSE;
            ST_PARSE: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // The pop strobe is registered from the next state so it is low exactly while in POP.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state      <= ST_IDLE;
            r_nextdata_n <= 1'b1;
            r_byte       <= '0;
        end else begin
            r_state      <= w_next;
            r_nextdata_n <= (w_next != ST_POP);
            if (r_state == ST_IDLE && ps2_ready) r_byte <= ps2_data;
        end
    end

    assign w_parse  = (r_state == ST_PARSE) && (r_skip == '0);
    assign w_prefix = (r_byte == SC_EXT) || (r_byte == SC_BRK) || (r_byte == SC_PAUSE) ||
                      (r_byte == SC_ERR0) || (r_byte == SC_ERR1);
    assign w_is_key = w_parse && !w_prefix;
    assign w_key    = {r_ext, r_byte};
    assign w_repeat = !r_brk && r_last_valid && (r_last_make == w_key);
    assign w_evt_wr = w_is_key && !(w_repeat && !REPEAT_EN);
    assign w_pop    = !w_empty && evt_ready;
    assign w_accept = w_evt_wr && (!w_full || w_pop);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_ext <= 1'b0; r_brk <= 1'b0; r_skip <= '0; r_err_cnt <= '0;
            r_last_make <= '0; r_last_valid <= 1'b0;
            r_shl <= 1'b0; r_shr <= 1'b0; r_ctl <= 1'b0; r_ctr <= 1'b0;
            r_altl <= 1'b0; r_altr <= 1'b0; r_caps <= 1'b0;
        end else if (r_state == ST_PARSE) begin
            if (r_skip != '0) begin
                r_skip <= r_skip - 8'd1;
            end else begin
                case (r_byte)
                    SC_EXT:   r_ext  <= 1'b1;
                    SC_BRK:   r_brk  <= 1'b1;
                    SC_PAUSE: r_skip <= 8'(PAUSE_SKIP);
                    SC_ERR0, SC_ERR1: begin
                        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
                        r_ext <= 1'b0;
                        r_brk <= 1'b0;
                    end
                    default: begin
                        r_ext <= 1'b0;
                        r_brk <= 1'b0;
                        if (!r_brk) begin
                            r_last_make  <= w_key;
                            r_last_valid <= 1'b1;
                        end else if (r_last_make == w_key) begin
                            r_last_valid <= 1'b0;
                        end
                        case (r_byte)
                            SC_LSHIFT: r_shl <= !r_brk;
                            SC_RSHIFT: r_shr <= !r_brk;
                            SC_CTRL:   if (r_ext) r_ctr <= !r_brk; else r_ctl <= !r_brk;
                            SC_ALT:    if (r_ext) r_altr <= !r_brk; else r_altl <= !r_brk;
                            SC_CAPS:   if (!r_brk && !w_repeat) r_caps <= !r_caps;
                            default:   ;
                        endcase
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_make_cnt <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_accept && !r_brk)  r_make_cnt <= r_make_cnt + 8'd1;
            if (w_evt_wr && !w_accept) r_ovf    <= 1'b1;
        end
    end

    kbd_evt_fifo #(
        .DEPTH (EVQ_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk     (clk),
        .clrn    (clrn),
        .i_wr    (w_evt_wr),
        .i_wdata ({r_brk, r_ext, r_byte}),
        .i_rd    (w_pop),
        .o_rdata (evt_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign ps2_nextdata_n = r_nextdata_n;
    assign evt_valid      = !w_empty;
    assign shift          = r_shl | r_shr;
    assign ctrl           = r_ctl | r_ctr;
    assign alt            = r_altl | r_altr;
    assign caps           = r_caps;
    assign make_count     = r_make_cnt;
    assign err_count      = r_err_cnt;
    assign evt_overflow   = r_ovf;

endmodule
